upcnt_monitor: RTL
==================

// Module: upcnt_monitor
// PURPOSE
//  Downstream consumer of the 4-bit up-counter's count output. Samples count every clk,
//  classifies each transition (hold / +1 step / wrap 15->0 / resync-to-0 / illegal jump),
//  emits wrap and compare-match pulses, and accumulates a saturating epoch (wrap) total.
//  An illegal jump sets a sticky error and freezes tracking until cleared.
// PARAMETERS
//  CW        4   width of monitored count (max value 2^CW-1)
//  EW        8   width of epoch accumulator
//  STALL_LIM 16  cycles of unchanged count with run=1 before stall flags (feature only)
// PORTS
//  clk      in   1   system clock, rising edge
//  a_reset  in   1   asynchronous reset, active-low
//  s_reset  in   1   synchronous clear, active-high (same net that drives the counter)
//  count    in   CW  counter value under observation
//  run      in   1   copy of the counter's start enable
//  cmp_val  in   CW  compare value for match pulse
//  clr_err  in   1   synchronous error clear, active-high
//  wrap     out  1   1-cycle pulse: legal wrap 2^CW-1 -> 0 seen
//  match    out  1   1-cycle pulse: count newly arrived at cmp_val
//  epoch    out  EW  number of wraps since clear, saturating at 2^EW-1
//  err      out  1   sticky illegal-transition flag
//  stall    out  1   count stuck while run=1 (0 when feature compiled out)
// BEHAVIOUR
//  - All outputs registered. a_reset=0: state=IDLE, prev=0, wrap=match=err=stall=0, epoch=0.
//  - Latency: transition between edge N-1 and edge N samples is reported in outputs after edge N.
//  - FSM states IDLE, TRACK, ERROR. Priority each edge: s_reset > clr_err > normal.
//  - s_reset=1 (any state): -> IDLE, epoch=0, err=0, stall=0, pulses 0, stall counter 0.
//  - IDLE: load prev<=count; -> TRACK; no pulses, no classification.
//  - TRACK, with c=count, p=prev (prev<=count every TRACK cycle):
//      c==p                  : hold, no pulse.
//      c==p+1 (no overflow)  : step; match=1 if c==cmp_val.
//      p==2^CW-1 && c==0     : wrap=1; epoch+=1 unless saturated; match=1 if cmp_val==0.
//      c==0 otherwise        : resync (counter cleared), legal, no wrap, match if cmp_val==0.
//      anything else         : err<=1, -> ERROR, no pulses, epoch unchanged.
//  - ERROR: outputs wrap/match held 0, epoch frozen, prev not updated, err=1.
//      clr_err=1 -> IDLE, err<=0 (epoch kept). Remains ERROR otherwise.
//  - clr_err in IDLE/TRACK: no effect.
//  - cmp_val sampled same edge as count; changing cmp_val while count holds does not pulse.
//  - epoch at 2^EW-1: further wraps still pulse wrap, epoch stays saturated.
//  - a_reset mid-operation: immediate async return to reset values, regardless of state.
// CONFIGURATION
//  UPCNT_MON_STALL_EN defined:
//    stall counter (width clog2(STALL_LIM+1)) increments in TRACK when run=1 and c==p;
//    clears on any count change, run=0, leaving TRACK, or s_reset.
//    stall=1 registered when counter reaches STALL_LIM; drops the cycle after count changes.
//    stall does not affect err or FSM.
//  not defined: no stall counter, stall tied to 0, run input unused.
// TESTING
//  1 a_reset=0 then 1, s_reset=0, count stepping 0..15,0 at 1/cycle -> one wrap pulse
//    after 15->0 sample, epoch=1, err=0.
//  2 cmp_val=5, count ramps 3,4,5,5,5,6 -> match exactly one cycle after first 5 sample.
//  3 count 6 -> 9 in TRACK -> err=1 next edge, epoch frozen, no wrap/match during
//    further wraps; clr_err=1 one cycle -> err=0, IDLE, then TRACK resumes.
//  4 count 7 -> 0 (counter s_reset upstream) -> no err, no wrap; cmp_val=0 gives match.
//  5 drive 300 wraps with EW=8 -> epoch saturates at 255, wrap pulse still on every wrap;
//    s_reset=1 -> epoch=0, state IDLE; a_reset=0 mid-ramp -> all outputs 0 immediately.
//  6 UPCNT_MON_STALL_EN, STALL_LIM=16, run=1, count held at 4 -> stall=1 after 16 held
//    cycles; count->5 -> stall=0; run=0 while held -> stall never asserts.

Source files
------------

// File: rtl/upcnt_monitor_if.sv
// upcnt_monitor_if: bus between the counter-side driver and the count monitor.
interface upcnt_monitor_if #(
  parameter int CW = 4,
  parameter int EW = 8
);
  logic          s_reset;
  logic [CW-1:0] count;
  logic          run;
  logic [CW-1:0] cmp_val;
  logic          clr_err;
  logic          wrap;
  logic          match;
  logic [EW-1:0] epoch;
  logic          err;
  logic          stall;
  modport master (output s_reset, count, run, cmp_val, clr_err, input wrap, match, epoch, err, stall);
  modport slave  (input s_reset, count, run, cmp_val, clr_err, output wrap, match, epoch, err, stall);
endinterface

// File: rtl/upcnt_monitor.sv
// upcnt_monitor: classifies counter transitions, pulses wrap/match, counts epochs; optional stall detect via UPCNT_MON_STALL_EN.
module upcnt_monitor #(
  parameter int CW        = 4,
  parameter int EW        = 8,
  parameter int STALL_LIM = 16
) (
  input logic            clk,
  input logic            a_reset,
  upcnt_monitor_if.slave bus
);
  typedef enum logic [1:0] {IDLE, TRACK, ERROR} state_t;
  localparam logic [CW-1:0] MAXC = {CW{1'b1}};
  localparam logic [EW-1:0] MAXE = {EW{1'b1}};
  state_t        r_state;
  logic [CW-1:0] r_prev;
  logic          r_wrap, r_match, r_err;
  logic [EW-1:0] r_epoch;
  logic          w_hold, w_step, w_wrap, w_zero, w_legal, w_stall;
  assign w_hold  = bus.count == r_prev;
  assign w_step  = (r_prev != MAXC) && (bus.count == r_prev + 1'b1);
  assign w_zero  = bus.count == '0;
  assign w_wrap  = (r_prev == MAXC) && w_zero;
  assign w_legal = w_hold || w_step || w_zero;
  // Transition tracker: s_reset beats clr_err, which only matters in ERROR.
  always_ff @(posedge clk or negedge a_reset) begin
    if (!a_reset) begin
      r_state <= IDLE;
      r_prev  <= '0;
      r_wrap  <= 1'b0;
      r_match <= 1'b0;
      r_err   <= 1'b0;
      r_epoch <= '0;
    end else if (bus.s_reset) begin
      r_state <= IDLE;
      r_prev  <= '0;
      r_wrap  <= 1'b0;
      r_match <= 1'b0;
      r_err   <= 1'b0;
      r_epoch <= '0;
    end else begin
      r_wrap  <= 1'b0;
      r_match <= 1'b0;
      case (r_state)
        IDLE: begin
          r_prev  <= bus.count;
          r_state <= TRACK;
        end
        TRACK: begin
          if (w_legal) begin
            r_prev  <= bus.count;
            r_wrap  <= w_wrap;
            r_match <= !w_hold && (bus.count == bus.cmp_val);
            r_epoch <= (w_wrap && r_epoch != MAXE) ? r_epoch + 1'b1 : r_epoch;
          end else begin
            r_err   <= 1'b1;
            r_state <= ERROR;
          end
        end
        ERROR: begin
          r_err   <= !bus.clr_err;
          r_state <= bus.clr_err ? IDLE : ERROR;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
`ifdef UPCNT_MON_STALL_EN
  localparam int SW = $clog2(STALL_LIM + 1);
  logic [SW-1:0] r_scnt;
  logic          r_stall;
  // Counts consecutive running holds in TRACK; any change, run drop or state exit restarts it.
  always_ff @(posedge clk or negedge a_reset) begin
    if (!a_reset) begin
      r_scnt  <= '0;
      r_stall <= 1'b0;
    end else if (bus.s_reset || r_state != TRACK || !bus.run || !w_hold) begin
      r_scnt  <= '0;
      r_stall <= 1'b0;
    end else begin
      r_scnt  <= (r_scnt == SW'(STALL_LIM)) ? r_scnt : r_scnt + 1'b1;
      r_stall <= r_scnt >= SW'(STALL_LIM - 1);
    end
  end
  assign w_stall = r_stall;
`else
  assign w_stall = 1'b0;
`endif
  assign bus.wrap  = r_wrap;
  assign bus.match = r_match;
  assign bus.epoch = r_epoch;
  assign bus.err   = r_err;
  assign bus.stall = w_stall;
endmodule
